// File: rtl/ram_rd_streamer_pkg.sv
// rtl/ram_rd_streamer_pkg.sv - shared types and helpers for the RAM read streamer
//
// Package rd_stream_pkg:
//   rd_state_t  : controller states
//   rd_entry_t  : one buffered beat {data, last}
//   credit_ok() : true while another read may be issued without overrunning the skid FIFO
package rd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_t;

    localparam int DEF_DATA_W = 64;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } rd_entry_t;

    // Every read in the RAM pipe already owns a FIFO slot, so the sum of
    // in-flight and buffered words must stay below the FIFO depth before a
    // new read is launched.
    function automatic logic credit_ok(input int unsigned inflight,
                                       input int unsigned buffered,
                                       input int unsigned depth);
        return (inflight + buffered) < depth;
    endfunction

endpackage

// File: rtl/ram_rd_streamer_if.sv
// rtl/ram_rd_streamer_if.sv - command, RAM read port and output stream bundle
//
// Signals:
//   io_start/io_base/io_len : read command (base address, word count)
//   io_busy/io_done         : command status
//   io_ram_enb/addrb/doutb  : RAM read port
//   io_out_valid/ready/data/last : output stream
// Modports: master = streamer side, slave = environment side.
interface ram_rd_streamer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic              io_start;
    logic [ADDR_W-1:0] io_base;
    logic [ADDR_W:0]   io_len;
    logic              io_busy;
    logic              io_done;
    logic              io_ram_enb;
    logic [ADDR_W-1:0] io_ram_addrb;
    logic [DATA_W-1:0] io_ram_doutb;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [DATA_W-1:0] io_out_data;
    logic              io_out_last;

    modport master (
        input  io_start, io_base, io_len, io_ram_doutb, io_out_ready,
        output io_busy, io_done, io_ram_enb, io_ram_addrb,
               io_out_valid, io_out_data, io_out_last
    );

    modport slave (
        output io_start, io_base, io_len, io_ram_doutb, io_out_ready,
        input  io_busy, io_done, io_ram_enb, io_ram_addrb,
               io_out_valid, io_out_data, io_out_last
    );
endinterface

// File: rtl/ram_rd_streamer_fifo.sv
// rtl/ram_rd_streamer_fifo.sv - skid FIFO absorbing RAM read returns
//
// Module sync_fifo_skid:
//   clock, reset  : clock, synchronous active-high reset
//   push/push_data: write one entry
//   pop           : remove head entry (only when not empty)
//   head          : head entry, read straight from the storage registers
//   count/empty/full : occupancy
module sync_fifo_skid #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/ram_rd_streamer.sv
// rtl/ram_rd_streamer.sv - streams a (base, length) range out of a buffer RAM
//
// Ports:
//   clock : single clock, also clocks the RAM read port
//   reset : synchronous active-high
//   io    : ram_rd_streamer_if.master (command, status, RAM read port, output stream)
// Reads are issued only while the skid FIFO has a free slot for every word in
// flight, so returning RAM data is written unconditionally.
module ram_rd_streamer
    import rd_stream_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = 10,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    ram_rd_streamer_if.master   io
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (DATA_W != DEF_DATA_W || FIFO_DEPTH < READ_LAT + 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("ram_rd_streamer: unsupported DATA_W/READ_LAT/FIFO_DEPTH combination");
    end

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] addrb_q;
    logic              busy_q;
    logic              done_q;
    logic              last_seen_q;
    logic              pipe_v [READ_LAT];
    logic              pipe_l [READ_LAT];

    logic              accept;
    logic              issue;
    logic              fire;
    int unsigned       inflight_cnt;
    rd_entry_t         push_entry;
    rd_entry_t         head_entry;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_cnt += 32'(pipe_v[i]);
        end
    end

    assign issue = (state_q == RUN) && (remaining_q != '0) &&
                   credit_ok(inflight_cnt, 32'(fifo_cnt), FIFO_DEPTH);

    assign io.io_ram_enb   = issue;
    assign io.io_ram_addrb = issue ? addr_q : addrb_q;

    assign push_entry = '{data: io.io_ram_doutb, last: pipe_l[READ_LAT-1]};

    sync_fifo_skid #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pipe_v[READ_LAT-1]),
        .push_data (push_entry),
        .pop       (fire),
        .head      (head_entry),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign io.io_out_valid = !fifo_empty;
    assign io.io_out_data  = head_entry.data;
    // Storage can hold a stale last flag once drained; only expose it with valid.
    assign io.io_out_last  = head_entry.last && !fifo_empty;
    assign fire            = !fifo_empty && io.io_out_ready;

    assign io.io_busy = busy_q;
    assign io.io_done = done_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.io_start) begin
                    accept  = 1'b1;
                    state_d = (io.io_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (remaining_q == '0 || (issue && remaining_q == (ADDR_W+1)'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Either the final beat leaves the FIFO this cycle, or it already has.
                if (inflight_cnt == 0 &&
                    ((fifo_empty && last_seen_q) ||
                     (fire && head_entry.last && fifo_cnt == CNT_W'(1)))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            addrb_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_seen_q <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_l[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN);
            if (state_q == FIN) begin
                busy_q <= 1'b0;
            end
            if (accept) begin
                addr_q      <= io.io_base;
                remaining_q <= io.io_len;
                busy_q      <= 1'b1;
                last_seen_q <= 1'b0;
            end
            if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                addrb_q     <= addr_q;
            end
            if (fire && head_entry.last) begin
                last_seen_q <= 1'b1;
            end
            pipe_v[0] <= issue;
            pipe_l[0] <= (remaining_q == (ADDR_W+1)'(1));
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// tb/tb_ram_rd_streamer.sv - self-checking bench for ram_rd_streamer
module tb_ram_rd_streamer;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int READ_LAT = 2;
    localparam int DEPTH = 4;
    localparam int RAM_N = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_rd_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_rd_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    // Behavioural RAM: enable register then output register.
    logic [DATA_W-1:0] ram [RAM_N];
    logic [DATA_W-1:0] ram_r1;
    initial begin
        for (int i = 0; i < RAM_N; i++) ram[i] = 64'(i) * 64'h0101;
    end
    always @(posedge clock) begin
        if (bus.io_ram_enb) ram_r1 <= ram[bus.io_ram_addrb];
        bus.io_ram_doutb <= ram_r1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [DATA_W-1:0] exp_d [$];
    bit                exp_l [$];
    int                exp_a [$];
    int                outstanding = 0;
    int                max_out = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_d;
    logic              prev_l;

    logic [DATA_W-1:0] got_d [$];
    int                got_cyc [$];
    int                got_a [$];
    int                done_cyc [$];
    int                enb_cnt;
    int                first_valid_cyc;
    int                busy_cycles;
    int                start_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: an accepted command expands into its address list and word list.
    task automatic cycle_check();
        if (reset) begin
            exp_d.delete(); exp_l.delete(); exp_a.delete();
            outstanding = 0;
            prev_stall = 0;
            return;
        end
        if (bus.io_start && !bus.io_busy) begin
            for (int k = 0; k < int'(bus.io_len); k++) begin
                int a;
                a = (int'(bus.io_base) + k) % RAM_N;
                exp_a.push_back(a);
                exp_d.push_back(64'(a) * 64'h0101);
                exp_l.push_back(k == int'(bus.io_len) - 1);
            end
        end
        if (bus.io_busy) busy_cycles++;
        if (bus.io_ram_enb) begin
            enb_cnt++;
            got_a.push_back(int'(bus.io_ram_addrb));
            if (exp_a.size() == 0) check("extra_read", 64'(1), 64'(0));
            else check("addrb", 64'(bus.io_ram_addrb), 64'(exp_a.pop_front()));
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
            check("credit_limit", 64'(outstanding <= DEPTH), 64'(1));
        end
        if (bus.io_out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("hold_data", bus.io_out_data, prev_d);
                check("hold_last", 64'(bus.io_out_last), 64'(prev_l));
            end
        end
        prev_stall = bus.io_out_valid && !bus.io_out_ready;
        prev_d = bus.io_out_data;
        prev_l = bus.io_out_last;
        if (bus.io_out_valid && bus.io_out_ready) begin
            if (exp_d.size() == 0) check("extra_beat", 64'(1), 64'(0));
            else begin
                check("beat_data", bus.io_out_data, exp_d.pop_front());
                check("beat_last", 64'(bus.io_out_last), 64'(exp_l.pop_front()));
            end
            outstanding--;
            got_d.push_back(bus.io_out_data);
            got_cyc.push_back(cyc);
        end
        if (bus.io_done) begin
            done_cyc.push_back(cyc);
            check("done_drained", 64'(exp_d.size()), 64'(0));
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cycle_check();
        @(posedge clock);
        #1;
        cyc++;
        if (ready_mode == 1) bus.io_out_ready = (cyc % 3 == 0);
        else bus.io_out_ready = 1'b1;
    endtask

    task automatic clear_logs();
        got_d.delete(); got_cyc.delete(); got_a.delete(); done_cyc.delete();
        enb_cnt = 0; first_valid_cyc = -1; busy_cycles = 0; max_out = 0;
    endtask

    task automatic start_cmd(input int base, input int len);
        bus.io_start = 1'b1;
        bus.io_base = ADDR_W'(base);
        bus.io_len = (ADDR_W+1)'(len);
        start_cyc = cyc;
        tick();
        bus.io_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cyc.size() == 0 && n < limit) begin
            tick();
            n++;
        end
        if (done_cyc.size() == 0) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(bus.io_busy), 64'(0));
        check({tag, "_done"},  64'(bus.io_done), 64'(0));
        check({tag, "_enb"},   64'(bus.io_ram_enb), 64'(0));
        check({tag, "_addrb"}, 64'(bus.io_ram_addrb), 64'(0));
        check({tag, "_valid"}, 64'(bus.io_out_valid), 64'(0));
        check({tag, "_last"},  64'(bus.io_out_last), 64'(0));
        check({tag, "_data"},  bus.io_out_data, 64'(0));
    endtask

    initial begin
        bus.io_start = 1'b0;
        bus.io_base = '0;
        bus.io_len = '0;
        bus.io_out_ready = 1'b1;
        clear_logs();

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Basic read
        clear_logs();
        start_cmd(5, 4);
        wait_done(50);
        check("basic_count", 64'(got_d.size()), 64'(4));
        if (got_d.size() == 4) begin
            check("basic_w0", got_d[0], 64'h0505);
            check("basic_w1", got_d[1], 64'h0606);
            check("basic_w2", got_d[2], 64'h0707);
            check("basic_w3", got_d[3], 64'h0808);
            check("basic_rate", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
            if (done_cyc.size() > 0)
                check("basic_done_lat", 64'(done_cyc[0] - got_cyc[3]), 64'(2));
        end
        check("basic_first_lat", 64'(first_valid_cyc - start_cyc), 64'(4));
        check("basic_busy_after", 64'(bus.io_busy), 64'(0));
        tick();

        // Backpressure
        clear_logs();
        ready_mode = 1;
        start_cmd(40, 16);
        wait_done(300);
        ready_mode = 0;
        check("bp_count", 64'(got_d.size()), 64'(16));
        check("bp_reads", 64'(enb_cnt), 64'(16));
        check("bp_max_outstanding", 64'(max_out), 64'(DEPTH));
        tick(); tick();

        // Address wrap
        clear_logs();
        start_cmd(1022, 4);
        wait_done(50);
        check("wrap_nreads", 64'(got_a.size()), 64'(4));
        if (got_a.size() == 4) begin
            check("wrap_a0", 64'(got_a[0]), 64'(1022));
            check("wrap_a1", 64'(got_a[1]), 64'(1023));
            check("wrap_a2", 64'(got_a[2]), 64'(0));
            check("wrap_a3", 64'(got_a[3]), 64'(1));
        end
        if (got_d.size() == 4) begin
            check("wrap_w0", got_d[0], 64'h401FE);
            check("wrap_w2", got_d[2], 64'h0);
            check("wrap_w3", got_d[3], 64'h0101);
        end
        tick();

        // Zero length
        clear_logs();
        start_cmd(7, 0);
        for (int i = 0; i < 6; i++) tick();
        check("zero_enb", 64'(enb_cnt), 64'(0));
        check("zero_valid", 64'(first_valid_cyc), 64'(-1));
        check("zero_done_cnt", 64'(done_cyc.size()), 64'(1));
        if (done_cyc.size() > 0)
            check("zero_done_lat", 64'(done_cyc[0] - start_cyc), 64'(2));
        check("zero_busy_cycles", 64'(busy_cycles), 64'(1));

        // Ignored start during RUN
        clear_logs();
        start_cmd(200, 6);
        tick();
        bus.io_start = 1'b1;
        bus.io_base = ADDR_W'(100);
        bus.io_len = (ADDR_W+1)'(3);
        tick(); tick(); tick();
        bus.io_start = 1'b0;
        wait_done(60);
        check("ign_count", 64'(got_d.size()), 64'(6));
        check("ign_reads", 64'(enb_cnt), 64'(6));
        if (got_d.size() == 6) begin
            check("ign_w0", got_d[0], 64'hC8C8);
            check("ign_w5", got_d[5], 64'hCDCD);
        end
        tick();

        // Reset mid-transfer
        clear_logs();
        start_cmd(300, 8);
        begin
            int n = 0;
            while (got_d.size() < 3 && n < 50) begin
                tick();
                n++;
            end
            if (got_d.size() < 3) check("mid_beats_timeout", 64'(got_d.size()), 64'(3));
        end
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_done", 64'(done_cyc.size()), 64'(0));
        clear_logs();
        start_cmd(0, 2);
        wait_done(50);
        check("post_count", 64'(got_d.size()), 64'(2));
        if (got_d.size() == 2) begin
            check("post_w0", got_d[0], 64'h0);
            check("post_w1", got_d[1], 64'h0101);
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
